// File: rtl/fft_pkg.sv
// Shared definitions for the R2SDF FFT pipeline: stage state encoding,
// constant-evaluable log2 helper and the default frame length.
package fft_pkg;

  localparam int FRAME_LEN_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } sdf_state_t;

  // Ceiling log2; clog2(1) = 0. Usable in parameter expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sdf_phase_cnt.sv
// Sample-index / block-index counter for one SDF stage. idx walks the
// delay-line positions; blk counts delay-line-length blocks in a frame.
module sdf_phase_cnt
  import fft_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int NBLK  = 2,
  parameter int IDX_W = 9,
  parameter int BLK_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             blk_en,
  output logic [IDX_W-1:0] idx,
  output logic [BLK_W-1:0] blk,
  output logic             idx_last,
  output logic             blk_last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(NBLK - 1);

  logic [IDX_W-1:0] idx_r;
  logic [BLK_W-1:0] blk_r;

  assign idx      = idx_r;
  assign blk      = blk_r;
  assign idx_last = (idx_r == IDX_MAX);
  assign blk_last = (blk_r == BLK_MAX);

  // Advance idx on enable; on idx wrap advance blk (when allowed), wrapping at the last block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
      blk_r <= {BLK_W{1'b0}};
    end else if (en) begin
      if (idx_last) begin
        idx_r <= {IDX_W{1'b0}};
        if (blk_en) begin
          blk_r <= blk_last ? {BLK_W{1'b0}} : (blk_r + BLK_W'(1));
        end else begin
          blk_r <= blk_r;
        end
      end else begin
        idx_r <= idx_r + IDX_W'(1);
        blk_r <= blk_r;
      end
    end else begin
      idx_r <= idx_r;
      blk_r <= blk_r;
    end
  end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: drives
// delay-line enable, butterfly mode, output mux and twiddle address, applies
// valid/ready flow control and drains the delay line at end of frame.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter  int FRAME_LEN = FRAME_LEN_DEF,
  parameter  int DEPTH     = 512,
  localparam int TW_W      = clog2(FRAME_LEN) - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_sof,
  output logic            i_ready,
  input  logic            o_ready,
  output logic            o_valid,
  output logic            o_sof,
  output logic            o_eof,
  output logic            dl_ena,
  output logic            bf_mode,
  output logic            out_sel,
  output logic [TW_W-1:0] tw_addr,
  output logic            busy,
  output logic            frame_done,
  output logic            sof_err
);

  localparam int IDX_W     = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int NBLK      = FRAME_LEN / DEPTH;
  localparam int BLK_W     = clog2(NBLK);
  localparam int STRIDE    = FRAME_LEN / (2 * DEPTH);
  localparam int STRIDE_SH = clog2(STRIDE);

  sdf_state_t       state_r, state_s;
  logic             first_blk_r, first_blk_s;
  logic             sof_err_r;
  logic             frame_done_r;

  logic [IDX_W-1:0] idx_s;
  logic [BLK_W-1:0] blk_s;
  logic             idx_last_s, blk_last_s;
  logic             i_ready_s, acc_s, adv_s, start_s;
  logic             cnt_en_s, blk_en_s, drain_done_s;
  logic             o_valid_s;
  logic [TW_W-1:0]  idx_ext_s;

  sdf_phase_cnt #(
    .DEPTH (DEPTH),
    .NBLK  (NBLK),
    .IDX_W (IDX_W),
    .BLK_W (BLK_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en_s),
    .blk_en   (blk_en_s),
    .idx      (idx_s),
    .blk      (blk_s),
    .idx_last (idx_last_s),
    .blk_last (blk_last_s)
  );

  // Upstream ready: always in IDLE, follows downstream while streaming, closed while draining.
  always_comb begin
    i_ready_s = 1'b0;
    case (state_r)
      IDLE:    i_ready_s = 1'b1;
      FILL:    i_ready_s = o_ready;
      BFLY:    i_ready_s = o_ready;
      DRAIN:   i_ready_s = 1'b0;
      default: i_ready_s = 1'b0;
    endcase
  end

  assign acc_s = i_valid & i_ready_s;

  // Next-state, advance and counter control. The frame-start sample taken in
  // IDLE occupies idx 0 of the first FILL block, so it also steps the counter.
  always_comb begin
    state_s      = state_r;
    first_blk_s  = first_blk_r;
    adv_s        = 1'b0;
    start_s      = 1'b0;
    blk_en_s     = 1'b1;
    drain_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s && i_sof) begin
          start_s = 1'b1;
          if (idx_last_s) begin
            state_s     = BFLY;
            first_blk_s = 1'b0;
          end else begin
            state_s     = FILL;
            first_blk_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        adv_s = acc_s;
        if (adv_s && idx_last_s) begin
          state_s     = BFLY;
          first_blk_s = 1'b0;
        end else begin
          state_s = FILL;
        end
      end
      BFLY: begin
        adv_s = acc_s;
        if (adv_s && idx_last_s) begin
          state_s = blk_last_s ? DRAIN : FILL;
        end else begin
          state_s = BFLY;
        end
      end
      DRAIN: begin
        adv_s    = o_ready;
        blk_en_s = 1'b0;
        if (adv_s && idx_last_s) begin
          state_s      = IDLE;
          drain_done_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s     = IDLE;
        first_blk_s = 1'b0;
      end
    endcase
  end

  assign cnt_en_s = adv_s | start_s;

  // State, first-block flag, sticky frame-sync error and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      first_blk_r  <= 1'b0;
      sof_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      first_blk_r  <= first_blk_s;
      frame_done_r <= drain_done_s;
      if (acc_s && i_sof && ((state_r == FILL) || (state_r == BFLY))) begin
        sof_err_r <= 1'b1;
      end else begin
        sof_err_r <= sof_err_r;
      end
    end
  end

  // Output beats: every advance except the first FILL block, whose samples only load the delay line.
  always_comb begin
    o_valid_s = 1'b0;
    case (state_r)
      IDLE:    o_valid_s = 1'b0;
      FILL:    o_valid_s = adv_s & ~first_blk_r;
      BFLY:    o_valid_s = adv_s;
      DRAIN:   o_valid_s = adv_s;
      default: o_valid_s = 1'b0;
    endcase
  end

  assign idx_ext_s = TW_W'(idx_s);

  assign i_ready    = i_ready_s;
  assign o_valid    = o_valid_s;
  assign o_sof      = o_valid_s & (idx_s == {IDX_W{1'b0}}) & (blk_s == BLK_W'(1));
  assign o_eof      = o_valid_s & (state_r == DRAIN) & idx_last_s;
  assign dl_ena     = adv_s;
  assign bf_mode    = (state_r == BFLY);
  assign out_sel    = (state_r == FILL) | (state_r == DRAIN);
  assign tw_addr    = out_sel ? (idx_ext_s << STRIDE_SH) : {TW_W{1'b0}};
  assign busy       = (state_r != IDLE);
  assign frame_done = frame_done_r;
  assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed scoreboard bench for sdf_stage_ctrl with FRAME_LEN=8 at DEPTH=2 and DEPTH=4.
module tb_sdf_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_valid, i_sof, o_ready, sel;

  logic       a_i_ready, a_o_valid, a_o_sof, a_o_eof, a_dl_ena, a_bf_mode, a_out_sel;
  logic       a_busy, a_frame_done, a_sof_err;
  logic [1:0] a_tw_addr;
  logic       b_i_ready, b_o_valid, b_o_sof, b_o_eof, b_dl_ena, b_bf_mode, b_out_sel;
  logic       b_busy, b_frame_done, b_sof_err;
  logic [1:0] b_tw_addr;

  sdf_stage_ctrl #(.FRAME_LEN(8), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid & ~sel), .i_sof(i_sof), .i_ready(a_i_ready),
    .o_ready(o_ready), .o_valid(a_o_valid), .o_sof(a_o_sof), .o_eof(a_o_eof),
    .dl_ena(a_dl_ena), .bf_mode(a_bf_mode), .out_sel(a_out_sel), .tw_addr(a_tw_addr),
    .busy(a_busy), .frame_done(a_frame_done), .sof_err(a_sof_err)
  );

  sdf_stage_ctrl #(.FRAME_LEN(8), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .i_valid(i_valid & sel), .i_sof(i_sof), .i_ready(b_i_ready),
    .o_ready(o_ready), .o_valid(b_o_valid), .o_sof(b_o_sof), .o_eof(b_o_eof),
    .dl_ena(b_dl_ena), .bf_mode(b_bf_mode), .out_sel(b_out_sel), .tw_addr(b_tw_addr),
    .busy(b_busy), .frame_done(b_frame_done), .sof_err(b_sof_err)
  );

  logic       m_i_ready, m_o_valid, m_o_sof, m_o_eof, m_dl_ena, m_bf_mode, m_out_sel;
  logic       m_busy, m_frame_done, m_sof_err;
  logic [1:0] m_tw_addr;

  assign m_i_ready    = sel ? b_i_ready    : a_i_ready;
  assign m_o_valid    = sel ? b_o_valid    : a_o_valid;
  assign m_o_sof      = sel ? b_o_sof      : a_o_sof;
  assign m_o_eof      = sel ? b_o_eof      : a_o_eof;
  assign m_dl_ena     = sel ? b_dl_ena     : a_dl_ena;
  assign m_bf_mode    = sel ? b_bf_mode    : a_bf_mode;
  assign m_out_sel    = sel ? b_out_sel    : a_out_sel;
  assign m_tw_addr    = sel ? b_tw_addr    : a_tw_addr;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_sof_err    = sel ? b_sof_err    : a_sof_err;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       osel;
    logic [1:0] tw;
  } beat_t;

  beat_t sb[$];
  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected output order: for each odd block, D sums (no twiddle), then D diffs at idx*STRIDE.
  task automatic push_frame(input int d);
    int nblk;
    int stride;
    beat_t e;
    nblk   = 8 / d;
    stride = 8 / (2 * d);
    for (int b = 1; b < nblk; b += 2) begin
      for (int i = 0; i < d; i++) begin
        e.sof = (b == 1) && (i == 0); e.eof = 1'b0; e.osel = 1'b0; e.tw = 2'd0;
        sb.push_back(e);
      end
      for (int i = 0; i < d; i++) begin
        e.sof = 1'b0; e.eof = (b == nblk - 1) && (i == d - 1); e.osel = 1'b1; e.tw = 2'(i * stride);
        sb.push_back(e);
      end
    end
  endtask

  // One clock cycle: drive at negedge, sample mid-cycle, score any output beat. -1 skips a check.
  task automatic cyc(input logic v, input logic s, input logic r,
                     input int ebf, input int eir, input int edl, input int eov);
    beat_t e;
    @(negedge clk);
    i_valid = v; i_sof = s; o_ready = r;
    #2;
    if (ebf >= 0) chk("bf_mode", m_bf_mode, ebf);
    if (eir >= 0) chk("i_ready", m_i_ready, eir);
    if (edl >= 0) chk("dl_ena", m_dl_ena, edl);
    if (eov >= 0) chk("o_valid", m_o_valid, eov);
    if (m_o_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("o_sof", m_o_sof, e.sof);
        chk("o_eof", m_o_eof, e.eof);
        chk("out_sel", m_out_sel, e.osel);
        chk("tw_addr", m_tw_addr, e.tw);
      end
    end
  endtask

  // Full frame: 8 samples (optional mid-frame sof, optional stall before one sample),
  // DRAIN with i_valid held high (optional stall), then frame_done / IDLE checks.
  task automatic run_frame(input int d, input int sof_at, input int stall_at,
                           input int stall_len, input int dstall_len);
    push_frame(d);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) cyc(1'b1, 1'b0, 1'b0, -1, 0, 0, 0);
      end
      cyc(1'b1, (k == 0) || (k == sof_at), 1'b1, (k / d) % 2, 1, (k == 0) ? -1 : 1, (k >= d) ? 1 : 0);
    end
    for (int j = 0; j < d; j++) begin
      if ((j == 1) && (dstall_len > 0)) begin
        for (int s = 0; s < dstall_len; s++) cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
      end
      cyc(1'b1, 1'b0, 1'b1, 0, 0, 1, 1);
    end
    cyc(1'b0, 1'b0, 1'b1, 0, 1, 0, 0);
    chk("frame_done_pulse", m_frame_done, 1);
    chk("busy_after_frame", m_busy, 0);
    cyc(1'b0, 1'b0, 1'b1, 0, 1, 0, 0);
    chk("frame_done_clear", m_frame_done, 0);
    chk("beats_outstanding", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; o_ready = 1'b0; sel = 1'b0;
    #1;
    chk("rst_i_ready", m_i_ready, 1);
    chk("rst_o_valid", m_o_valid, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_frame_done", m_frame_done, 0);
    chk("rst_sof_err", m_sof_err, 0);
    chk("rst_tw_addr", m_tw_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Back-to-back frame, DEPTH=2.
    run_frame(2, -1, -1, 0, 0);
    chk("sof_err_clean", m_sof_err, 0);

    // Same frame with stalls in block 1 and in DRAIN.
    run_frame(2, -1, 3, 3, 2);

    // Samples without sof in IDLE are dropped.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 0, 1, 0, 0);
      chk("idle_drop_busy", m_busy, 0);
    end
    run_frame(2, -1, -1, 0, 0);

    // sof on input sample 5 mid-frame: counted normally, sticky error.
    run_frame(2, 4, -1, 0, 0);
    chk("sof_err_set", m_sof_err, 1);
    cyc(1'b0, 1'b0, 1'b1, 0, 1, 0, 0);
    chk("sof_err_sticky", m_sof_err, 1);

    // Reset asserted mid-BFLY with o_ready high.
    push_frame(2);
    for (int k = 0; k < 3; k++) cyc(1'b1, k == 0, 1'b1, -1, 1, -1, -1);
    @(negedge clk);
    i_valid = 1'b1; i_sof = 1'b0; o_ready = 1'b1;
    #1;
    chk("pre_rst_bfly", m_bf_mode, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_i_ready", m_i_ready, 1);
    chk("mid_rst_o_valid", m_o_valid, 0);
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_sof_err", m_sof_err, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 0, 1, 0, 0);
      chk("post_rst_no_done", m_frame_done, 0);
    end

    // DEPTH=4 instance: FILL 4, BFLY 4, DRAIN 4 with tw 0..3.
    sel = 1'b1;
    run_frame(4, -1, -1, 0, 0);
    run_frame(4, -1, 6, 2, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
